h_func_seq: RTL and testbench

Iterative Twofish h-function engine for the 128-bit-key schedule. It consumes the q0/q1 byte permutations and produces the 32-bit h(X, L) word used to build the round subkeys (A_i, B_i). One q-permutation layer is evaluated per clock, then the MDS multiply. This reuses a single bank of four q-lookups instead of twelve in parallel. It sits between the key-word splitter (M_e, M_o) and the PHT/rotate stage of the key generator.

---
 rtl/h_func_seq_if.sv | 27 ++
 rtl/h_func_seq.sv | 176 +++++++++++++++++
 tb/tb_h_func_seq.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/h_func_seq_if.sv
// ============================================================================
// h_func_seq_if : request/result bundle for the iterative Twofish h-function.
// Revision 1.0
// ============================================================================
`default_nettype none

interface h_func_seq_if;
   logic        start;
   logic [31:0] x_in;
   logic [31:0] l0_in;
   logic [31:0] l1_in;
   logic        busy;
   logic        done;
   logic [31:0] z_out;

   modport master (
      output start, x_in, l0_in, l1_in,
      input  busy, done, z_out
   );

   modport slave (
      input  start, x_in, l0_in, l1_in,
      output busy, done, z_out
   );
endinterface

`default_nettype wire

// File: rtl/h_func_seq.sv
// ============================================================================
// h_func_seq : Twofish h(X, L) for k=2, one q-layer per clock, then MDS.
// Revision 1.0
// ============================================================================
`default_nettype none

module h_func_seq (
   input  logic        clk,
   input  logic        rst_n,
   h_func_seq_if.slave bus
);

   // 4-bit t-tables, entry 0 in the most significant nibble.
   localparam logic [63:0] c_Q0_T0 = 64'h817D6F320B59ECA4;
   localparam logic [63:0] c_Q0_T1 = 64'hECB81235F4A6709D;
   localparam logic [63:0] c_Q0_T2 = 64'hBA5E6D90C8F32471;
   localparam logic [63:0] c_Q0_T3 = 64'hD7F4126E9B3085CA;
   localparam logic [63:0] c_Q1_T0 = 64'h28BDF76E31940AC5;
   localparam logic [63:0] c_Q1_T1 = 64'h1E2B4C376DA5F908;
   localparam logic [63:0] c_Q1_T2 = 64'h4C75169A0ED82B3F;
   localparam logic [63:0] c_Q1_T3 = 64'hB951C3DE647F208A;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_QA   = 3'd1,
      S_QB   = 3'd2,
      S_QC   = 3'd3,
      S_MDS  = 3'd4
   } state_t;

   state_t      r_state;
   logic [31:0] r_y;
   logic [31:0] r_l0;
   logic [31:0] r_l1;
   logic [31:0] r_z;
   logic        r_busy;
   logic        r_done;

   logic [3:0]  w_qsel;
   logic [31:0] w_lx;
   logic [31:0] w_q;
   logic [31:0] w_next_y;
   logic [31:0] w_z;

   function automatic logic [3:0] nib(input logic [63:0] t, input logic [3:0] i);
      return t[{~i, 2'b00} +: 4];
   endfunction

   function automatic logic [7:0] q_perm(input logic sel, input logic [7:0] x);
      logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
      a0 = x[7:4];
      b0 = x[3:0];
      a1 = a0 ^ b0;
      b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};
      a2 = nib(sel ? c_Q1_T0 : c_Q0_T0, a1);
      b2 = nib(sel ? c_Q1_T1 : c_Q0_T1, b1);
      a3 = a2 ^ b2;
      b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
      a4 = nib(sel ? c_Q1_T2 : c_Q0_T2, a3);
      b4 = nib(sel ? c_Q1_T3 : c_Q0_T3, b3);
      return {b4, a4};
   endfunction

   // Multiply by x modulo x^8+x^6+x^5+x^3+1.
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h69 : 8'h00);
   endfunction

   function automatic logic [7:0] mul5b(input logic [7:0] a);
      logic [7:0] m2, m4, m8, m16, m32, m64;
      m2  = xt(a);
      m4  = xt(m2);
      m8  = xt(m4);
      m16 = xt(m8);
      m32 = xt(m16);
      m64 = xt(m32);
      return m64 ^ m16 ^ m8 ^ m2 ^ a;
   endfunction

   function automatic logic [7:0] mulef(input logic [7:0] a);
      logic [7:0] m2, m4, m8, m16, m32, m64, m128;
      m2   = xt(a);
      m4   = xt(m2);
      m8   = xt(m4);
      m16  = xt(m8);
      m32  = xt(m16);
      m64  = xt(m32);
      m128 = xt(m64);
      return m128 ^ m64 ^ m32 ^ m8 ^ m4 ^ m2 ^ a;
   endfunction

   // Bit i of w_qsel picks q1 (1) or q0 (0) for byte i in the current layer.
   always_comb begin
      w_qsel = 4'b0000;
      w_lx   = 32'h0;
      case (r_state)
         S_QA: begin
            w_qsel = 4'b1010;
            w_lx   = r_l1;
         end
         S_QB: begin
            w_qsel = 4'b1100;
            w_lx   = r_l0;
         end
         S_QC:    w_qsel = 4'b0101;
         default: w_qsel = 4'b0000;
      endcase
   end

   generate
      for (genvar i = 0; i < 4; i++) begin : g_qbank
         assign w_q[8*i +: 8] = q_perm(w_qsel[i], r_y[8*i +: 8]);
      end
   endgenerate

   assign w_next_y = w_q ^ w_lx;

   assign w_z[7:0]   = r_y[7:0]          ^ mulef(r_y[15:8]) ^ mul5b(r_y[23:16]) ^ mul5b(r_y[31:24]);
   assign w_z[15:8]  = mul5b(r_y[7:0])   ^ mulef(r_y[15:8]) ^ mulef(r_y[23:16]) ^ r_y[31:24];
   assign w_z[23:16] = mulef(r_y[7:0])   ^ mul5b(r_y[15:8]) ^ r_y[23:16]        ^ mulef(r_y[31:24]);
   assign w_z[31:24] = mulef(r_y[7:0])   ^ r_y[15:8]        ^ mulef(r_y[23:16]) ^ mul5b(r_y[31:24]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_y     <= 32'h0;
         r_l0    <= 32'h0;
         r_l1    <= 32'h0;
         r_z     <= 32'h0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_y     <= bus.x_in;
                  r_l0    <= bus.l0_in;
                  r_l1    <= bus.l1_in;
                  r_busy  <= 1'b1;
                  r_state <= S_QA;
               end
            end
            S_QA: begin
               r_y     <= w_next_y;
               r_state <= S_QB;
            end
            S_QB: begin
               r_y     <= w_next_y;
               r_state <= S_QC;
            end
            S_QC: begin
               r_y     <= w_next_y;
               r_state <= S_MDS;
            end
            S_MDS: begin
               r_z     <= w_z;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.z_out = r_z;

endmodule

`default_nettype wire

// File: tb/tb_h_func_seq.sv
// ============================================================================
// tb_h_func_seq : vector table, corner sequences and random traffic for h_func_seq.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_h_func_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   h_func_seq_if bus();

   h_func_seq u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Twofish t-tables: q0 t0..t3, then q1 t0..t3; entry 0 is the top nibble.
   localparam bit [63:0] QT [0:7] = '{
      64'h817D6F320B59ECA4, 64'hECB81235F4A6709D, 64'hBA5E6D90C8F32471, 64'hD7F4126E9B3085CA,
      64'h28BDF76E31940AC5, 64'h1E2B4C376DA5F908, 64'h4C75169A0ED82B3F, 64'hB951C3DE647F208A
   };
   localparam int MDS [0:15] = '{
      'h01, 'hEF, 'h5B, 'h5B,
      'h5B, 'hEF, 'hEF, 'h01,
      'hEF, 'h5B, 'h01, 'hEF,
      'hEF, 'h01, 'hEF, 'h5B
   };

   typedef struct {
      logic [31:0] x;
      logic [31:0] l0;
      logic [31:0] l1;
      logic [31:0] z;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   int n_dut_done = 0;
   int n_mod_done = 0;

   int          m_cnt  = 0;
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [31:0] m_z    = 32'h0;
   logic [31:0] m_pend = 32'h0;

   function automatic int tlook(int q, int t, int i);
      bit [63:0] row;
      row = QT[q*4 + t];
      return int'((row >> (4 * (15 - i))) & 64'hF);
   endfunction

   function automatic int ror4(int v);
      return ((v >> 1) | ((v & 1) << 3)) & 15;
   endfunction

   function automatic int q_ref(int q, int x);
      int a, b, a2, b2;
      a  = (x >> 4) & 15;
      b  = x & 15;
      a2 = tlook(q, 0, a ^ b);
      b2 = tlook(q, 1, (a ^ ror4(b) ^ (8 * a)) & 15);
      a  = tlook(q, 2, a2 ^ b2);
      b  = tlook(q, 3, (a2 ^ ror4(b2) ^ (8 * a2)) & 15);
      return b * 16 + a;
   endfunction

   function automatic int gf_mul(int a, int b);
      int p;
      p = 0;
      for (int k = 0; k < 8; k++) begin
         if ((b >> k) & 1) p = p ^ a;
         a = a << 1;
         if (a & 'h100) a = a ^ 'h169;
      end
      return p & 'hFF;
   endfunction

   function automatic logic [31:0] h_ref(logic [31:0] x, logic [31:0] l0, logic [31:0] l1);
      int xb[4], a[4], b[4], y[4];
      int z;
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         xb[i] = int'((x  >> (8*i)) & 32'hFF);
         a[i]  = int'((l0 >> (8*i)) & 32'hFF);
         b[i]  = int'((l1 >> (8*i)) & 32'hFF);
      end
      y[0] = q_ref(1, q_ref(0, q_ref(0, xb[0]) ^ b[0]) ^ a[0]);
      y[1] = q_ref(0, q_ref(0, q_ref(1, xb[1]) ^ b[1]) ^ a[1]);
      y[2] = q_ref(1, q_ref(1, q_ref(0, xb[2]) ^ b[2]) ^ a[2]);
      y[3] = q_ref(0, q_ref(1, q_ref(1, xb[3]) ^ b[3]) ^ a[3]);
      r = 32'h0;
      for (int row = 0; row < 4; row++) begin
         z = 0;
         for (int col = 0; col < 4; col++) z = z ^ gf_mul(MDS[row*4 + col], y[col]);
         r = r | (32'(z) << (8*row));
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt  = 0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_z    = 32'h0;
   endtask

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         m_done = 1'b0;
         if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_z    = m_pend;
               m_done = 1'b1;
            end
         end else if (bus.start) begin
            m_pend = h_ref(bus.x_in, bus.l0_in, bus.l1_in);
            m_cnt  = 4;
         end
         m_busy = (m_cnt != 0);
      end
      @(negedge clk);
      if (bus.done) n_dut_done++;
      if (m_done)   n_mod_done++;
      check("busy",  {31'h0, bus.busy}, {31'h0, m_busy});
      check("done",  {31'h0, bus.done}, {31'h0, m_done});
      check("z_out", bus.z_out, m_z);
   endtask

   vec_t        vecs[40];
   logic [31:0] zs[40];
   logic [31:0] ka, kb, k0, k1, lr0, lr1;
   int          nbusy, nd0, gap;

   initial begin
      bus.start = 1'b0;
      bus.x_in  = 32'h0;
      bus.l0_in = 32'h0;
      bus.l1_in = 32'h0;

      #1;
      check("reset_busy", {31'h0, bus.busy}, 32'h0);
      check("reset_done", {31'h0, bus.done}, 32'h0);
      check("reset_z",    bus.z_out,         32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Key-schedule vectors for the all-zero 128-bit key (M_e = M_o = 0).
      for (int i = 0; i < 20; i++) begin
         vecs[2*i].x      = 32'(i) * 32'h02020202;
         vecs[2*i].l0     = 32'h0;
         vecs[2*i].l1     = 32'h0;
         vecs[2*i+1].x    = 32'(i) * 32'h02020202 + 32'h01010101;
         vecs[2*i+1].l0   = 32'h0;
         vecs[2*i+1].l1   = 32'h0;
      end
      for (int i = 0; i < 40; i++) vecs[i].z = h_ref(vecs[i].x, vecs[i].l0, vecs[i].l1);

      for (int i = 0; i < 40; i++) begin
         bus.start = 1'b1;
         bus.x_in  = vecs[i].x;
         bus.l0_in = vecs[i].l0;
         bus.l1_in = vecs[i].l1;
         nbusy = 0;
         tick();
         bus.start = 1'b0;
         bus.x_in  = ~vecs[i].x;
         if (bus.busy) nbusy++;
         for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.busy) nbusy++;
         end
         check("vec_done", {31'h0, bus.done}, 32'h1);
         check("vec_z", bus.z_out, vecs[i].z);
         check("vec_busy_cycles", 32'(nbusy), 32'd4);
         zs[i] = bus.z_out;
      end

      ka = zs[0];
      kb = {zs[1][23:0], zs[1][31:24]};
      k0 = ka + kb;
      k1 = ka + 2 * kb;
      k1 = {k1[22:0], k1[31:23]};
      check("K0", k0, 32'h52C54DDE);
      check("K1", k1, 32'h11F0626D);

      // Start while busy: the second request must be ignored.
      lr0 = 32'h9A3C5E71;
      lr1 = 32'h0F1E2D3C;
      nd0 = n_dut_done;
      bus.start = 1'b1; bus.x_in = 32'hAAAAAAAA; bus.l0_in = lr0; bus.l1_in = lr1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.start = 1'b1; bus.x_in = 32'h55555555;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      check("swb_done", {31'h0, bus.done}, 32'h1);
      check("swb_z", bus.z_out, h_ref(32'hAAAAAAAA, lr0, lr1));
      for (int c = 0; c < 6; c++) tick();
      check("swb_single_done", 32'(n_dut_done - nd0), 32'd1);

      // Continuous start with inputs changing every cycle.
      nd0 = n_dut_done;
      bus.start = 1'b1;
      for (int c = 0; c < 20; c++) begin
         bus.x_in  = $urandom;
         bus.l0_in = $urandom;
         bus.l1_in = $urandom;
         tick();
      end
      bus.start = 1'b0;
      check("cont_done_count", 32'(n_dut_done - nd0), 32'd4);
      while (m_cnt != 0) tick();

      // Reset in the middle of a computation.
      bus.start = 1'b1; bus.x_in = 32'h12345678;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("midrst_busy", {31'h0, bus.busy}, 32'h0);
      check("midrst_done", {31'h0, bus.done}, 32'h0);
      check("midrst_z",    bus.z_out,         32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      nd0 = n_dut_done;
      for (int c = 0; c < 10; c++) tick();
      check("midrst_no_done", 32'(n_dut_done - nd0), 32'd0);

      // Random traffic with idle gaps and noise on the inputs while busy.
      for (int n = 0; n < 2000; n++) begin
         bus.start = 1'b0;
         gap = int'($urandom_range(0, 7));
         for (int g = 0; g < gap; g++) begin
            bus.x_in = $urandom;
            tick();
         end
         bus.start = 1'b1;
         bus.x_in  = $urandom;
         bus.l0_in = $urandom;
         bus.l1_in = $urandom;
         tick();
         while (m_cnt != 0) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.x_in  = $urandom;
            bus.l0_in = $urandom;
            bus.l1_in = $urandom;
            tick();
         end
      end
      bus.start = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      check("total_done_count", 32'(n_dut_done), 32'(n_mod_done));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
